pc_sequencer: RTL and testbench

Registered program-counter controller for the single-cycle CPU with the cache/memory hierarchy. Each cycle it holds the current PC and picks the next one: sequential PC+4, a branch/jump target, a hold while the instruction or data memory reports busy, or a permanent halt. It supersedes the free-running PC increment path. It also keeps a count of advanced instructions for bench visibility.

---
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for the single-cycle CPU.
// Each cycle the PC either steps by 4, takes a branch/jump target, holds
// while instruction or data memory is busy, or freezes after HALT.
// INSTR_COUNT tracks how many times the PC has advanced since reset.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          OFFSET_W = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IBUSY,
    input  logic                DBUSY,
    input  logic                BRANCH_TAKEN,
    input  logic                JUMP,
    input  logic [OFFSET_W-1:0] OFFSET,
    input  logic                HALT,
    output logic [31:0]         PC,
    output logic                PC_VALID,
    output logic                STALL,
    output logic [31:0]         INSTR_COUNT
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] cnt_q;
    logic        valid_q;

    logic        busy;
    logic [31:0] off_ext;
    logic [31:0] seq_pc;
    logic [31:0] tgt_pc;
    logic [31:0] pc_d;
    logic [31:0] cnt_d;

    assign busy = IBUSY | DBUSY;

    // Next-PC datapath: inputs of the current cycle only, so in a stall
    // release the branch/jump info of the release cycle is what counts.
    // All sums wrap modulo 2^32.
    always_comb begin
        off_ext = {{(32-OFFSET_W){OFFSET[OFFSET_W-1]}}, OFFSET};
        seq_pc  = pc_q + 32'd4;
        tgt_pc  = seq_pc + (off_ext << 2);
        pc_d    = (JUMP | BRANCH_TAKEN) ? tgt_pc : seq_pc;
        cnt_d   = cnt_q + 32'd1;
    end

    // Sequencer FSM: state, PC, advance counter and registered PC_VALID.
    // Busy takes priority over HALT in RUN; HALT is not looked at in WAIT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    if (busy) begin
                        state_q <= WAIT;
                    end else if (HALT) begin
                        state_q <= HALTED;
                        valid_q <= 1'b0;
                    end else begin
                        pc_q  <= pc_d;
                        cnt_q <= cnt_d;
                    end
                end
                WAIT: begin
                    if (!busy) begin
                        state_q <= RUN;
                        pc_q    <= pc_d;
                        cnt_q   <= cnt_d;
                    end
                end
                HALTED: begin
                    // Frozen until reset.
                end
                default: begin
                    state_q <= BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // STALL follows the busy inputs combinationally, only while live.
    always_comb begin
        STALL = busy && ((state_q == RUN) || (state_q == WAIT));
    end

    assign PC          = pc_q;
    assign PC_VALID    = valid_q;
    assign INSTR_COUNT = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a directed vector table on a RESET_PC=0 instance,
// plus hand sequences for wrap/halt (RESET_PC=0xFFFFFFFC instance) and
// reset during a stall.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IBUSY, DBUSY, BRANCH_TAKEN, JUMP, HALT;
    logic [7:0]  OFFSET;

    logic [31:0] PC_a, CNT_a, PC_b, CNT_b;
    logic        VLD_a, STL_a, VLD_b, STL_b;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pc_sequencer #(.RESET_PC(32'd0), .OFFSET_W(8)) dut_a (
        .CLK(CLK), .RESET(RESET), .IBUSY(IBUSY), .DBUSY(DBUSY),
        .BRANCH_TAKEN(BRANCH_TAKEN), .JUMP(JUMP), .OFFSET(OFFSET), .HALT(HALT),
        .PC(PC_a), .PC_VALID(VLD_a), .STALL(STL_a), .INSTR_COUNT(CNT_a)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .OFFSET_W(8)) dut_b (
        .CLK(CLK), .RESET(RESET), .IBUSY(IBUSY), .DBUSY(DBUSY),
        .BRANCH_TAKEN(BRANCH_TAKEN), .JUMP(JUMP), .OFFSET(OFFSET), .HALT(HALT),
        .PC(PC_b), .PC_VALID(VLD_b), .STALL(STL_b), .INSTR_COUNT(CNT_b)
    );

    typedef struct {
        logic        ib, db, br, jp;
        logic [7:0]  off;
        logic        hlt;
        logic        stall;  // expected before the edge
        logic [31:0] pc;     // expected after the edge
        logic        vld;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ib, logic db, logic br, logic jp,
                                logic [7:0] off, logic hlt, logic stall,
                                logic [31:0] pc, logic vld, logic [31:0] cnt);
        vec_t v;
        v.ib = ib; v.db = db; v.br = br; v.jp = jp; v.off = off; v.hlt = hlt;
        v.stall = stall; v.pc = pc; v.vld = vld; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ib, input logic db, input logic br,
                         input logic jp, input logic [7:0] off, input logic hlt);
        RESET = rst; IBUSY = ib; DBUSY = db; BRANCH_TAKEN = br;
        JUMP = jp; OFFSET = off; HALT = hlt;
    endtask

    // One cycle: drive at negedge, then land 1 time unit after the posedge.
    task automatic step(input logic rst, input logic ib, input logic db, input logic br,
                        input logic jp, input logic [7:0] off, input logic hlt);
        @(negedge CLK);
        drive(rst, ib, db, br, jp, off, hlt);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        drive(1'b1, 0, 0, 0, 0, 8'h00, 0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(1'b1, 0, 0, 0, 0, 8'h00, 0);

        // -------- main table on dut_a (RESET_PC = 0) --------
        //                 ib db br jp off    hlt stl pc            vld cnt
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 32'h00, 1, 0));   // BOOT edge
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 32'h04, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 32'h08, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 32'h0C, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 32'h10, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 32'h14, 1, 5));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 32'h18, 1, 6));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 32'h1C, 1, 7));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 32'h20, 1, 8));
        vecs.push_back(mk(0, 0, 1, 0, 8'hFC, 0, 0, 32'h14, 1, 9));   // 0x24-16
        vecs.push_back(mk(0, 0, 0, 1, 8'h03, 0, 0, 32'h24, 1, 10));  // 0x18+12
        vecs.push_back(mk(0, 0, 1, 1, 8'h01, 0, 0, 32'h2C, 1, 11));  // both -> TGT
        vecs.push_back(mk(0, 0, 0, 1, 8'hF6, 0, 0, 32'h08, 1, 12));  // 0x30-40
        // IBUSY for 3 cycles with JUMP off=2 pending
        vecs.push_back(mk(1, 0, 0, 1, 8'h02, 0, 1, 32'h08, 1, 12));
        vecs.push_back(mk(1, 0, 0, 1, 8'h02, 0, 1, 32'h08, 1, 12));
        vecs.push_back(mk(1, 0, 0, 1, 8'h02, 0, 1, 32'h08, 1, 12));
        vecs.push_back(mk(0, 0, 0, 1, 8'h02, 0, 0, 32'h14, 1, 13));  // 0x0C+8
        // overlapping busy: I in 1-2, D in 2-4
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1, 32'h14, 1, 13));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 1, 32'h14, 1, 13));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 32'h14, 1, 13));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 32'h14, 1, 13));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 32'h18, 1, 14));
        // HALT during stall entry and in WAIT is ignored
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 32'h18, 1, 14));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 32'h1C, 1, 15));
        // HALT in RUN takes effect; then everything is frozen
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 32'h1C, 0, 15));
        vecs.push_back(mk(0, 0, 1, 1, 8'h05, 0, 0, 32'h1C, 0, 15));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 0, 32'h1C, 0, 15));

        do_reset();
        check("reset pc",    PC_a,  32'h0);
        check("reset valid", {31'd0, VLD_a}, 32'd0);
        check("reset stall", {31'd0, STL_a}, 32'd0);
        check("reset count", CNT_a, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(1'b0, vecs[i].ib, vecs[i].db, vecs[i].br, vecs[i].jp, vecs[i].off, vecs[i].hlt);
            #1;
            check($sformatf("v%0d stall", i), {31'd0, STL_a}, {31'd0, vecs[i].stall});
            @(posedge CLK);
            #1;
            check($sformatf("v%0d pc", i),    PC_a,  vecs[i].pc);
            check($sformatf("v%0d valid", i), {31'd0, VLD_a}, {31'd0, vecs[i].vld});
            check($sformatf("v%0d count", i), CNT_a, vecs[i].cnt);
        end

        // -------- wrap and halt on dut_b (RESET_PC = 0xFFFFFFFC) --------
        do_reset();
        check("b reset pc", PC_b, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 8'h00, 0);                       // BOOT edge
        check("b boot pc", PC_b, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 8'h00, 0);                       // wrap to 0
        check("b wrap pc", PC_b, 32'h0);
        check("b wrap count", CNT_b, 32'd1);
        step(0, 0, 0, 1, 0, 8'hFE, 0);                       // 4-8 wraps negative
        check("b neg tgt pc", PC_b, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 8'h00, 0);
        check("b wrap2 pc", PC_b, 32'h0);
        step(0, 0, 0, 0, 0, 8'h00, 1);                       // halt
        check("b halt pc", PC_b, 32'h0);
        check("b halt valid", {31'd0, VLD_b}, 32'd0);
        step(0, 0, 0, 1, 1, 8'h10, 0);
        check("b halted pc", PC_b, 32'h0);
        check("b halted count", CNT_b, 32'd3);

        // -------- reset in the middle of a stall (dut_a) --------
        do_reset();
        step(0, 0, 0, 0, 0, 8'h00, 0);                       // BOOT
        step(0, 0, 0, 0, 0, 8'h00, 0);                       // PC=4
        step(0, 1, 0, 0, 0, 8'h00, 0);                       // enter WAIT
        step(0, 1, 0, 0, 0, 8'h00, 0);                       // stay WAIT
        check("mid pc before reset", PC_a, 32'h4);
        check("mid stall before reset", {31'd0, STL_a}, 32'd1);
        step(1, 1, 0, 0, 0, 8'h00, 0);                       // reset with IBUSY high
        check("mid reset pc", PC_a, 32'h0);
        check("mid reset count", CNT_a, 32'd0);
        check("mid reset stall", {31'd0, STL_a}, 32'd0);
        check("mid reset valid", {31'd0, VLD_a}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
